// File: rtl/bool_eqn_eval_pkg.sv
// ---------------------------------------------------------------------------
// bool_eqn_pkg
// Shared widths, the reset truth table and small helper functions for the
// 4-input boolean equation evaluator.
//   TT_W        : truth-table width (one bit per input combination)
//   IDX_W       : table index width ({a,b,c,d})
//   DEFAULT_TT  : table loaded at reset, encodes (a&b)|(~c&d)
//   tt_index()  : packs the four equation inputs into a table index
//   ref_eqn()   : the default equation written out directly
// ---------------------------------------------------------------------------
package bool_eqn_pkg;

   localparam int TT_W  = 16;
   localparam int IDX_W = 4;

   localparam logic [TT_W-1:0] DEFAULT_TT = 16'hF222;

   // a is the most significant index bit, d the least significant.
   function automatic logic [IDX_W-1:0] tt_index(input logic a, input logic b,
                                                 input logic c, input logic d);
      return {a, b, c, d};
   endfunction

   function automatic logic ref_eqn(input logic a, input logic b,
                                    input logic c, input logic d);
      return (a & b) | (~c & d);
   endfunction

endpackage

// File: rtl/bool_eqn_eval_if.sv
// ---------------------------------------------------------------------------
// bool_eqn_eval_if
// Bundles the equation inputs, the table write port and the two outputs of
// bool_eqn_eval. Clock and reset stay outside the interface.
//   a,b,c,d   : equation inputs (a = index MSB)
//   tt_we     : truth-table write enable
//   tt_wdata  : new truth table
//   tt_rdata  : current truth-table contents
//   z         : registered function result
// Modports: master drives inputs and observes outputs, slave is the block.
// ---------------------------------------------------------------------------
interface bool_eqn_eval_if;
   import bool_eqn_pkg::*;

   logic            a;
   logic            b;
   logic            c;
   logic            d;
   logic            tt_we;
   logic [TT_W-1:0] tt_wdata;
   logic [TT_W-1:0] tt_rdata;
   logic            z;

   modport master (
      output a, b, c, d, tt_we, tt_wdata,
      input  tt_rdata, z
   );

   modport slave (
      input  a, b, c, d, tt_we, tt_wdata,
      output tt_rdata, z
   );

endinterface

// File: rtl/bool_eqn_eval_lut.sv
// ---------------------------------------------------------------------------
// bool_eqn_lut
// Pure-combinational 16:1 mux: picks the truth-table bit addressed by idx.
//   tt  : truth table, bit i is the function value for index i
//   idx : {a,b,c,d}
//   f   : selected function bit
// ---------------------------------------------------------------------------
module bool_eqn_lut
   import bool_eqn_pkg::*;
(
   input  logic [TT_W-1:0]  tt,
   input  logic [IDX_W-1:0] idx,
   output logic             f
);

   assign f = tt[idx];

endmodule

// File: rtl/bool_eqn_eval.sv
// ---------------------------------------------------------------------------
// bool_eqn_eval
// Registered 4-input boolean function evaluator, z = f(a,b,c,d), where f is
// held in a reloadable 16-entry truth table.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (restores DEFAULT_TT, clears z)
//   bus  : bool_eqn_eval_if slave (inputs a..d, table write port, tt_rdata, z)
// z has exactly one cycle of latency. A table write and an evaluation in the
// same cycle use the old table; the new table applies from the next edge.
// ---------------------------------------------------------------------------
module bool_eqn_eval
   import bool_eqn_pkg::*;
#(
   parameter logic [TT_W-1:0] DEFAULT_TT = bool_eqn_pkg::DEFAULT_TT
)
(
   input  logic               clk,
   input  logic               rst,
   bool_eqn_eval_if.slave     bus
);

   logic [TT_W-1:0]  tt_q;
   logic [TT_W-1:0]  tt_d;
   logic             z_q;
   logic             z_d;
   logic [IDX_W-1:0] idx;
   logic             lut_f;

   assign idx = tt_index(bus.a, bus.b, bus.c, bus.d);

   // Lookup always reads the registered table, so a write in this cycle
   // cannot affect this cycle's result.
   bool_eqn_lut u_lut (
      .tt  (tt_q),
      .idx (idx),
      .f   (lut_f)
   );

   always_comb begin
      tt_d = tt_q;
      if (bus.tt_we) begin
         tt_d = bus.tt_wdata;
      end
      z_d = lut_f;
   end

   // Reset takes priority over any table write in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tt_q <= DEFAULT_TT;
         z_q  <= 1'b0;
      end else begin
         tt_q <= tt_d;
         z_q  <= z_d;
      end
   end

   assign bus.tt_rdata = tt_q;
   assign bus.z        = z_q;

endmodule

// File: tb/tb_bool_eqn_eval.sv
// ---------------------------------------------------------------------------
// tb_bool_eqn_eval
// Self-checking bench for bool_eqn_eval. Each driven cycle pushes the
// expected z onto a scoreboard queue; after the clock edge the entry is
// popped and compared with the DUT output. A small table model tracks the
// expected truth-table contents.
// ---------------------------------------------------------------------------
module tb_bool_eqn_eval;
   import bool_eqn_pkg::*;

   logic clk;
   logic rst;

   bool_eqn_eval_if bus ();

   bool_eqn_eval #(.DEFAULT_TT(16'hF222)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks;
   int errors;
   logic            exp_q[$];
   logic [TT_W-1:0] model_tt;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute bound on run time so the bench never hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [TT_W-1:0] observed,
                              input logic [TT_W-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Expected z for index idx under the model table; the default table is
   // cross-checked against the written-out equation.
   function automatic logic model_z(input logic [TT_W-1:0] tbl, input logic a,
                                    input logic b, input logic c, input logic d);
      logic [IDX_W-1:0] i;
      i = {a, b, c, d};
      if (tbl == 16'hF222) return ref_eqn(a, b, c, d);
      return tbl[i];
   endfunction

   // Drive one cycle, push the expected z, clock it, then pop and compare.
   task automatic applyStimulus(input string tag, input logic r,
                                input logic [IDX_W-1:0] idx, input logic we,
                                input logic [TT_W-1:0] wdata);
      logic exp_z;
      rst          = r;
      bus.a        = idx[3];
      bus.b        = idx[2];
      bus.c        = idx[1];
      bus.d        = idx[0];
      bus.tt_we    = we;
      bus.tt_wdata = wdata;
      exp_q.push_back(r ? 1'b0 : model_z(model_tt, idx[3], idx[2], idx[1], idx[0]));
      @(posedge clk);
      #1;
      if (r)       model_tt = 16'hF222;
      else if (we) model_tt = wdata;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got empty scoreboard, expected entry", tag);
      end else begin
         exp_z = exp_q.pop_front();
         checkOutput({tag, "_z"}, {15'd0, bus.z}, {15'd0, exp_z});
      end
      checkOutput({tag, "_tt"}, bus.tt_rdata, model_tt);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      model_tt     = 16'h0000;
      rst          = 1'b1;
      bus.a        = 1'b0;
      bus.b        = 1'b0;
      bus.c        = 1'b0;
      bus.d        = 1'b0;
      bus.tt_we    = 1'b0;
      bus.tt_wdata = 16'h0000;

      // Reset for two cycles, with a write attempt that must be ignored.
      applyStimulus("rst0", 1'b1, 4'h0, 1'b1, 16'h1234);
      applyStimulus("rst1", 1'b1, 4'hF, 1'b0, 16'h0000);
      checkOutput("rst_tt_default", bus.tt_rdata, 16'hF222);

      // Exhaustive sweep of the default table.
      for (int i = 0; i < 16; i++) begin
         applyStimulus($sformatf("sweep%0d", i), 1'b0, 4'(i), 1'b0, 16'h0000);
      end

      // Spot values against the published default table.
      applyStimulus("ref0001", 1'b0, 4'b0001, 1'b0, 16'h0);
      checkOutput("const0001", {15'd0, bus.z}, 16'd1);
      applyStimulus("ref0011", 1'b0, 4'b0011, 1'b0, 16'h0);
      checkOutput("const0011", {15'd0, bus.z}, 16'd0);
      applyStimulus("ref1100", 1'b0, 4'b1100, 1'b0, 16'h0);
      checkOutput("const1100", {15'd0, bus.z}, 16'd1);
      applyStimulus("ref1010", 1'b0, 4'b1010, 1'b0, 16'h0);
      checkOutput("const1010", {15'd0, bus.z}, 16'd0);

      // Reset with a=b=1: z must be 0, then 1 after release.
      applyStimulus("rstab", 1'b1, 4'b1100, 1'b0, 16'h0);
      checkOutput("rstab_const", {15'd0, bus.z}, 16'd0);
      applyStimulus("relab", 1'b0, 4'b1100, 1'b0, 16'h0);
      checkOutput("relab_const", {15'd0, bus.z}, 16'd1);

      // Reload table 8000 while 1111: old table gives 1.
      applyStimulus("ld8000", 1'b0, 4'b1111, 1'b1, 16'h8000);
      checkOutput("ld8000_z_old", {15'd0, bus.z}, 16'd1);
      checkOutput("ld8000_rdata", bus.tt_rdata, 16'h8000);
      applyStimulus("new1111", 1'b0, 4'b1111, 1'b0, 16'h0);
      checkOutput("new1111_const", {15'd0, bus.z}, 16'd1);
      applyStimulus("new1100", 1'b0, 4'b1100, 1'b0, 16'h0);
      checkOutput("new1100_const", {15'd0, bus.z}, 16'd0);

      // Restore default via write, then collide: load 0000 under input 0001.
      applyStimulus("ldF222", 1'b0, 4'b0000, 1'b1, 16'hF222);
      applyStimulus("ld0000", 1'b0, 4'b0001, 1'b1, 16'h0000);
      checkOutput("coll_old", {15'd0, bus.z}, 16'd1);
      applyStimulus("coll_new", 1'b0, 4'b0001, 1'b0, 16'h0);
      checkOutput("coll_new_const", {15'd0, bus.z}, 16'd0);

      // Reset mid-operation discards the loaded table.
      applyStimulus("mid_rst", 1'b1, 4'b0101, 1'b0, 16'h0);
      checkOutput("mid_rst_tt", bus.tt_rdata, 16'hF222);
      checkOutput("mid_rst_z", {15'd0, bus.z}, 16'd0);
      applyStimulus("mid_rel", 1'b0, 4'b0101, 1'b0, 16'h0);
      checkOutput("mid_rel_const", {15'd0, bus.z}, 16'd1);

      // Random inputs with occasional table writes.
      for (int n = 0; n < 200; n++) begin
         logic           we;
         logic [TT_W-1:0] wd;
         we = ($urandom_range(0, 7) == 0);
         wd = 16'($urandom);
         applyStimulus($sformatf("rnd%0d", n), 1'b0, 4'($urandom_range(0, 15)), we, wd);
      end

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
